// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - c, borr = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borr
);

  assign diff = a ^ b ^ c;
  assign borr = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single full_subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  sub_state_t       r_state, w_state_d;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic             r_borrow, r_bout, r_ovf, r_busy, r_done;
  logic             w_diff, w_borr, w_accept, w_last;

  full_subtractor u_cell (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .c   (r_borrow),
    .diff(w_diff),
    .borr(w_borr)
  );

  assign w_last = (r_cnt == LastBit);

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_d = SHIFT;
          w_accept  = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) w_state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          w_state_d = SHIFT;
          w_accept  = 1'b1;
        end else begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= (w_state_d == SHIFT);
      r_done  <= (w_state_d == DONE);
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_borrow <= bus.bin;
        r_cnt    <= '0;
      end else if (r_state == SHIFT) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_borrow <= w_borr;
        r_res    <= {w_diff, r_res[WIDTH-1:1]};
        if (!w_last) begin
          r_cnt <= r_cnt + CntW'(1);
        end else begin
          // Overflow: borrow into the MSB differs from the borrow out of it.
          r_diff <= {w_diff, r_res[WIDTH-1:1]};
          r_bout <= w_borr;
          r_ovf  <= r_borrow ^ w_borr;
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(W)) u_if ();

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for diff/borrow, signed range for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, ui, sa, sb, si;
    ua = int'(a);
    ub = int'(b);
    ui = ua - ub - int'(bin);
    d  = ui[W-1:0];
    bo = (ui < 0);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    si = sa - sb - int'(bin);
    ov = (si < -(1 << (W - 1))) || (si > (1 << (W - 1)) - 1);
  endfunction

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    u_if.start = 1'b1;
    u_if.a     = a;
    u_if.b     = b;
    u_if.bin   = bin;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    u_if.a     = W'($urandom);
    u_if.b     = W'($urandom);
    u_if.bin   = 1'($urandom);
  endtask

  // Called #1 after the accept edge; optionally pulses start during SHIFT cycle ign_at.
  task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                             input int ign_at, input string tag);
    logic [W-1:0] ed;
    logic         eb, eo;
    model(a, b, bin, ed, eb, eo);
    check({tag, "_busy_start"}, 32'(u_if.busy), 32'd1);
    for (int i = 1; i <= W; i++) begin
      if (i == ign_at) begin
        u_if.start = 1'b1;
        u_if.a     = W'($urandom);
        u_if.b     = W'($urandom);
      end
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      if (i < W) begin
        check({tag, "_done_early"}, 32'(u_if.done), 32'd0);
      end else begin
        check({tag, "_done"}, 32'(u_if.done), 32'd1);
        check({tag, "_busy_end"}, 32'(u_if.busy), 32'd0);
        check({tag, "_diff"}, 32'(u_if.diff), 32'(ed));
        check({tag, "_bout"}, 32'(u_if.bout), 32'(eb));
        check({tag, "_ovf"}, 32'(u_if.ovf), 32'(eo));
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int ign_at, input string tag);
    drive_start(a, b, bin);
    wait_result(a, b, bin, ign_at, tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    int           done_seen;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    u_if.start = 1'b0;
    u_if.a     = '0;
    u_if.b     = '0;
    u_if.bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check("rst_diff", 32'(u_if.diff), 32'd0);
    check("rst_bout", 32'(u_if.bout), 32'd0);
    check("rst_ovf", 32'(u_if.ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(8'h5A, 8'h3C, 1'b0, 0, "t5a3c");
    @(posedge clk); #1;
    do_op(8'h00, 8'h01, 1'b0, 0, "t0001");
    @(posedge clk); #1;
    do_op(8'h80, 8'h01, 1'b0, 0, "t8001");
    @(posedge clk); #1;
    do_op(8'h10, 8'h0F, 1'b1, 0, "t100f");
    @(posedge clk); #1;
    check("done_single", 32'(u_if.done), 32'd0);
    check("idle_busy", 32'(u_if.busy), 32'd0);

    // Start pulse mid-shift must be ignored; then back-to-back accept from DONE.
    do_op(8'h5A, 8'h3C, 1'b0, 3, "ignore");
    do_op(8'h80, 8'h01, 1'b0, 0, "b2b");

    // Abort mid-operation; previous result (7F, ovf=1) must be cleared.
    drive_start(8'h00, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(u_if.busy), 32'd0);
    check("abort_done", 32'(u_if.done), 32'd0);
    check("abort_diff", 32'(u_if.diff), 32'd0);
    check("abort_bout", 32'(u_if.bout), 32'd0);
    check("abort_ovf", 32'(u_if.ovf), 32'd0);
    done_seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    do_op(8'h33, 8'h44, 1'b1, 0, "fresh");

    for (int n = 0; n < 1000; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
      do_op(ra, rb, rbin, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
